// File: rtl/move_ctrl_pkg.sv
// rtl/move_ctrl_pkg.sv - address map, grid geometry and FSM state codes for the move commit controller
package move_ctrl_pkg;

  localparam int GRID_SIZE   = 16;
  localparam int MEM_DEPTH   = 64;
  localparam int GRID_ROWS   = 9;
  localparam int P0_BASE     = 1;
  localparam int P1_BASE     = 10;
  localparam int SEL_BASE    = 19;
  localparam int TURN_WORD   = 28;
  localparam int BUTTON_WORD = 29;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RD_TURN = 4'd1;
  localparam logic [3:0] ST_V_SEL   = 4'd2;
  localparam logic [3:0] ST_V_P0    = 4'd3;
  localparam logic [3:0] ST_V_P1    = 4'd4;
  localparam logic [3:0] ST_C_SEL   = 4'd5;
  localparam logic [3:0] ST_C_OWN   = 4'd6;
  localparam logic [3:0] ST_W_TURN  = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;
  localparam logic [3:0] ST_REJECT  = 4'd9;

endpackage

// File: rtl/button_edge_detect.sv
// rtl/button_edge_detect.sv - rising-edge detector for the place button
// The history bit resets high so a button held through reset cannot fire.
module button_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_prev <= 1'b1;
    else     btn_prev <= btn;
  end

  assign rise = btn & ~btn_prev;

endmodule

// File: rtl/move_commit_controller.sv
// rtl/move_commit_controller.sv - validates a one-hot selection grid and commits it into the mover's grid
module move_commit_controller
  import move_ctrl_pkg::*;
#(
  parameter int SIZE           = GRID_SIZE,
  parameter int DEPTH          = MEM_DEPTH,
  parameter int ROWS           = GRID_ROWS,
  parameter int PLAYER0_START  = P0_BASE,
  parameter int PLAYER1_START  = P1_BASE,
  parameter int SELECTED_START = SEL_BASE,
  parameter int TURN_ADDR      = TURN_WORD,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [SIZE-1:0]   button_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [SIZE-1:0]   mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [SIZE-1:0]   mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              reject,
  output logic              last_player
);

  localparam int R_W = $clog2(ROWS);
  localparam int CW  = $clog2(SIZE + 1) + 1;

  logic [3:0]      state;
  logic [SIZE-1:0] sel;
  logic            turn;
  logic            conflict;
  logic [R_W-1:0]  r;
  logic [1:0]      cnt;

  logic            rise;
  logic            last_row;
  logic            hit;
  logic            we_req;
  logic [CW-1:0]   ones;
  logic [1:0]      cnt_sat;
  logic            unused_button_bits;

  assign unused_button_bits = ^button_data[SIZE-1:1];

  button_edge_detect u_button_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (button_data[0]),
    .rise (rise)
  );

  assign last_row = (r == R_W'(ROWS - 1));
  assign hit      = |(sel & mem_rdata);

  // Only "zero, one, more than one" matters, so the bit count saturates at 2.
  always_comb begin
    ones = CW'(cnt);
    for (int i = 0; i < SIZE; i++) ones = ones + CW'(mem_rdata[i]);
    cnt_sat = (ones >= CW'(2)) ? 2'd2 : ones[1:0];
  end

  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    we_req    = 1'b0;
    case (state)
      ST_RD_TURN: mem_raddr = ADDR_W'(TURN_ADDR);
      ST_V_SEL:   mem_raddr = ADDR_W'(SELECTED_START) + ADDR_W'(r);
      ST_V_P0:    mem_raddr = ADDR_W'(PLAYER0_START) + ADDR_W'(r);
      ST_V_P1:    mem_raddr = ADDR_W'(PLAYER1_START) + ADDR_W'(r);
      ST_C_SEL:   mem_raddr = ADDR_W'(SELECTED_START) + ADDR_W'(r);
      ST_C_OWN: begin
        mem_raddr = (turn ? ADDR_W'(PLAYER1_START) : ADDR_W'(PLAYER0_START)) + ADDR_W'(r);
        mem_waddr = mem_raddr;
        mem_wdata = mem_rdata | sel;
        we_req    = 1'b1;
      end
      ST_W_TURN: begin
        mem_waddr = ADDR_W'(TURN_ADDR);
        mem_wdata = {{(SIZE-1){1'b0}}, ~turn};
        we_req    = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_we  = we_req & mem_gnt;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign reject  = (state == ST_REJECT);
  assign mem_req = busy & ~done & ~reject;

  // DONE and REJECT do not use the port, so they retire without waiting for a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= '0;
      turn        <= 1'b0;
      conflict    <= 1'b0;
      r           <= '0;
      cnt         <= '0;
      last_player <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (enable && rise) state <= ST_RD_TURN;
    end else if (state == ST_DONE || state == ST_REJECT) begin
      state <= ST_IDLE;
    end else if (mem_gnt) begin
      case (state)
        ST_RD_TURN: begin
          turn     <= mem_rdata[0];
          r        <= '0;
          cnt      <= '0;
          conflict <= 1'b0;
          state    <= ST_V_SEL;
        end
        ST_V_SEL: begin
          sel   <= mem_rdata;
          cnt   <= cnt_sat;
          state <= ST_V_P0;
        end
        ST_V_P0: begin
          conflict <= conflict | hit;
          state    <= ST_V_P1;
        end
        ST_V_P1: begin
          conflict <= conflict | hit;
          if (!last_row) begin
            r     <= r + 1'b1;
            state <= ST_V_SEL;
          end else if (cnt == 2'd1 && !(conflict | hit)) begin
            r     <= '0;
            state <= ST_C_SEL;
          end else begin
            state <= ST_REJECT;
          end
        end
        ST_C_SEL: begin
          sel   <= mem_rdata;
          state <= ST_C_OWN;
        end
        ST_C_OWN: begin
          if (!last_row) begin
            r     <= r + 1'b1;
            state <= ST_C_SEL;
          end else begin
            state <= ST_W_TURN;
          end
        end
        ST_W_TURN: begin
          last_player <= turn;
          state       <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_commit_controller.sv
// tb/tb_move_commit_controller.sv - self-checking bench with a memory model and a grid-level reference model
module tb_move_commit_controller;

  localparam int P0 = 1;
  localparam int P1 = 10;
  localparam int SL = 19;
  localparam int TA = 28;
  localparam int NR = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] button_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [5:0]  mem_raddr;
  logic [15:0] mem_rdata;
  logic [5:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        reject;
  logic        last_player;

  logic [15:0] mem     [64];
  logic [15:0] exp_mem [64];
  int errors = 0;
  int checks = 0;
  int wr_cnt;
  int gnt_viol;
  bit          pend;
  logic [5:0]  pa;
  logic [15:0] pd;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_raddr];

  move_commit_controller dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .button_data (button_data),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .busy        (busy),
    .done        (done),
    .reject      (reject),
    .last_player (last_player)
  );

  // Write request is sampled mid-cycle and committed just after the edge.
  task automatic tick();
    @(negedge clk);
    pend = 1'b0;
    if (mem_we) begin
      wr_cnt++;
      if (!mem_gnt) gnt_viol++;
      pend = 1'b1;
      pa = mem_waddr;
      pd = mem_wdata;
    end
    @(posedge clk);
    #1;
    if (pend) mem[pa] = pd;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Grid-level view of a move: exactly one selected cell, unoccupied by either player.
  task automatic model(output bit valid);
    int  n_ones = 0;
    bit  conf = 0;
    bit  t;
    t = mem[TA][0];
    for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < NR; i++) begin
      n_ones += $countones(mem[SL+i]);
      if ((mem[SL+i] & (mem[P0+i] | mem[P1+i])) != 16'h0) conf = 1;
    end
    valid = (n_ones == 1) && !conf;
    if (valid) begin
      for (int i = 0; i < NR; i++) exp_mem[(t ? P1 : P0) + i] = mem[(t ? P1 : P0) + i] | mem[SL+i];
      exp_mem[TA] = {15'h0, ~t};
    end
  endtask

  // outc: 1 = done, 2 = reject, 3 = aborted by reset, 0 = timed out
  task automatic run_move(input int st_at, input int st_len, input int abort_k,
                          input bit repress, input bit drop_en,
                          output int lat, output int outc);
    lat = -1; outc = 0; wr_cnt = 0; gnt_viol = 0;
    mem_gnt = 1'b1;
    button_data = 16'h0001;
    tick();
    for (int k = 1; k <= 120; k++) begin
      mem_gnt = !(k >= st_at && k < st_at + st_len);
      if (k == 3) button_data = 16'h0000;
      if (drop_en && k == 5) enable = 1'b0;
      if (repress && k == 8) button_data = 16'h0001;
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        lat = k; outc = 3;
        break;
      end
      if (done || reject) begin
        lat = k; outc = done ? 1 : 2;
        break;
      end
      tick();
    end
    if (outc != 3) begin
      mem_gnt = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || reject !== 1'b0)
        begin errors++; $display("FAIL return_to_idle busy=%b done=%b reject=%b want 0 0 0", busy, done, reject); end
      button_data = 16'h0000;
      enable = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; button_data = 16'h0; mem_gnt = 1'b0;
    clear_mem();
    tick(); tick();
    checks++;
    if ({busy, done, reject, mem_req, mem_we, last_player} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got=%b want=000000", {busy, done, reject, mem_req, mem_we, last_player}); end
    checks++;
    if (mem_raddr !== 6'h0 || mem_waddr !== 6'h0 || mem_wdata !== 16'h0)
      begin errors++; $display("FAIL reset_bus raddr=%h waddr=%h wdata=%h want 0", mem_raddr, mem_waddr, mem_wdata); end
    rst = 1'b0; enable = 1'b1;
    tick();
  endtask

  task automatic test_commit_p0();
    int lat, outc; bit v;
    clear_mem();
    mem[SL+4] = 16'h0010;
    model(v);
    run_move(0, 0, 0, 0, 0, lat, outc);
    checks++; if (outc !== 1 || lat !== 48) begin errors++; $display("FAIL p0_done outc=%0d lat=%0d want 1 48", outc, lat); end
    checks++; if (mem[5] !== 16'h0010 || mem[TA] !== 16'h0001) begin errors++; $display("FAIL p0_mem row4=%h turn=%h want 0010 0001", mem[5], mem[TA]); end
    checks++; if (mem_diff() !== 0 || wr_cnt !== 10) begin errors++; $display("FAIL p0_image diff=%0d writes=%0d want 0 10", mem_diff(), wr_cnt); end
    checks++; if (last_player !== 1'b0) begin errors++; $display("FAIL p0_last_player got=%b want=0", last_player); end
  endtask

  task automatic test_occupied();
    int lat, outc; bit v;
    clear_mem();
    mem[SL+4] = 16'h0010;
    mem[P1+4] = 16'h0010;
    model(v);
    run_move(0, 0, 0, 0, 0, lat, outc);
    checks++; if (outc !== 2 || lat !== 29) begin errors++; $display("FAIL occupied_reject outc=%0d lat=%0d want 2 29", outc, lat); end
    checks++; if (wr_cnt !== 0 || mem_diff() !== 0) begin errors++; $display("FAIL occupied_nowrite writes=%0d diff=%0d want 0 0", wr_cnt, mem_diff()); end
  endtask

  task automatic test_bad_selection();
    int lat, outc; bit v;
    for (int p = 0; p < 2; p++) begin
      clear_mem();
      mem[P0+3] = 16'h1234;
      if (p == 0) begin mem[SL+0] = 16'h0001; mem[SL+8] = 16'h0100; end
      model(v);
      run_move(0, 0, 0, 0, 0, lat, outc);
      checks++; if (outc !== 2 || lat !== 29) begin errors++; $display("FAIL badsel%0d_reject outc=%0d lat=%0d want 2 29", p, outc, lat); end
      checks++; if (wr_cnt !== 0 || mem_diff() !== 0) begin errors++; $display("FAIL badsel%0d_nowrite writes=%0d diff=%0d want 0 0", p, wr_cnt, mem_diff()); end
    end
  endtask

  task automatic test_commit_p1();
    int lat, outc; bit v;
    clear_mem();
    mem[TA]   = 16'h0001;
    mem[SL+2] = 16'h0004;
    mem[P1+2] = 16'h0001;
    model(v);
    run_move(0, 0, 0, 0, 0, lat, outc);
    checks++; if (outc !== 1 || lat !== 48) begin errors++; $display("FAIL p1_done outc=%0d lat=%0d want 1 48", outc, lat); end
    checks++; if (mem[12] !== 16'h0005 || mem[TA] !== 16'h0000) begin errors++; $display("FAIL p1_mem addr12=%h turn=%h want 0005 0000", mem[12], mem[TA]); end
    checks++; if (last_player !== 1'b1 || mem_diff() !== 0) begin errors++; $display("FAIL p1_state last=%b diff=%0d want 1 0", last_player, mem_diff()); end
  endtask

  task automatic test_stall();
    int lat, outc; bit v;
    clear_mem();
    mem[SL+4] = 16'h0010;
    model(v);
    run_move(35, 5, 0, 0, 0, lat, outc);
    checks++; if (outc !== 1 || lat !== 53) begin errors++; $display("FAIL stall_done outc=%0d lat=%0d want 1 53", outc, lat); end
    checks++; if (gnt_viol !== 0 || mem_diff() !== 0 || mem[5] !== 16'h0010) begin errors++; $display("FAIL stall_mem viol=%0d diff=%0d row4=%h want 0 0 0010", gnt_viol, mem_diff(), mem[5]); end
  endtask

  task automatic test_button_and_busy();
    int lat, outc; bit v;
    clear_mem();
    mem[SL+4] = 16'h0010;
    rst = 1'b1; button_data = 16'h0001;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL held_button busy=%b req=%b want 0 0", busy, mem_req); end
    button_data = 16'h0000;
    tick();
    model(v);
    run_move(0, 0, 0, 1, 1, lat, outc);
    checks++; if (outc !== 1 || lat !== 48 || mem_diff() !== 0) begin errors++; $display("FAIL repress_done outc=%0d lat=%0d diff=%0d want 1 48 0", outc, lat, mem_diff()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repress_ignored busy=%b want 0", busy); end
    model(v);
    run_move(0, 0, 0, 0, 0, lat, outc);
    checks++; if (outc !== 2 || lat !== 29 || wr_cnt !== 0) begin errors++; $display("FAIL back_to_back outc=%0d lat=%0d writes=%0d want 2 29 0", outc, lat, wr_cnt); end
  endtask

  task automatic test_reset_mid_commit();
    int lat, outc; bit v;
    clear_mem();
    mem[SL+1] = 16'h0002;
    mem[P0+1] = 16'h8000;
    model(v);
    for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
    exp_mem[P0+1] = 16'h8002;
    run_move(0, 0, 36, 0, 0, lat, outc);
    checks++; if ({busy, done, reject, mem_req, mem_we} !== 5'b0 || mem_raddr !== 6'h0)
      begin errors++; $display("FAIL abort_outputs flags=%b raddr=%h want 00000 00", {busy, done, reject, mem_req, mem_we}, mem_raddr); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (wr_cnt !== 3 || mem_diff() !== 0 || busy !== 1'b0)
      begin errors++; $display("FAIL abort_mem writes=%0d diff=%0d busy=%b want 3 0 0", wr_cnt, mem_diff(), busy); end
    button_data = 16'h0000;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int lat, outc, mode, len, at, rr, bb;
    bit v, t;
    for (int it = 0; it < 24; it++) begin
      clear_mem();
      mem[TA] = 16'($urandom);
      for (int i = 0; i < NR; i++) begin
        mem[P0+i] = 16'($urandom & $urandom & $urandom);
        mem[P1+i] = 16'($urandom & $urandom & $urandom);
      end
      mode = $urandom_range(0, 3);
      rr = $urandom_range(0, NR-1);
      bb = $urandom_range(0, 15);
      if (mode <= 1) mem[SL+rr] = 16'd1 << bb;
      if (mode == 1) mem[(($urandom_range(0, 1) == 1) ? P1 : P0) + rr] |= 16'd1 << bb;
      if (mode == 2) begin
        mem[SL+rr] = 16'd1 << bb;
        mem[SL+$urandom_range(0, NR-1)] |= 16'd1 << $urandom_range(0, 15);
      end
      t = mem[TA][0];
      model(v);
      len = $urandom_range(0, 4);
      at = $urandom_range(2, 25);
      run_move(at, len, 0, 0, 0, lat, outc);
      checks++; if (outc !== (v ? 1 : 2) || lat !== (v ? 48 : 29) + len)
        begin errors++; $display("FAIL rand%0d_outcome outc=%0d lat=%0d want %0d %0d", it, outc, lat, v ? 1 : 2, (v ? 48 : 29) + len); end
      checks++; if (mem_diff() !== 0 || wr_cnt !== (v ? 10 : 0) || gnt_viol !== 0)
        begin errors++; $display("FAIL rand%0d_mem diff=%0d writes=%0d viol=%0d want 0 %0d 0", it, mem_diff(), wr_cnt, gnt_viol, v ? 10 : 0); end
      if (v) begin
        checks++; if (last_player !== t) begin errors++; $display("FAIL rand%0d_last_player got=%b want=%b", it, last_player, t); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit_p0();
    test_occupied();
    test_bad_selection();
    test_commit_p1();
    test_stall();
    test_button_and_busy();
    test_reset_mid_commit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
